inv_trans_divider: RTL and testbench

- Iterative reciprocal unit for the scene-recovery stage of the haze-removal pipeline.
- Takes a transmission estimate t in Q0.8 and produces the inverse-transmission operand Inv_Trans in Q2.6, i.e. the value 16384 / t.
- Its output feeds the downstream (I - A) * (1/t) multiplier.
- Restoring division, one quotient bit per clock, with valid/ready handshakes on both sides.

---
 rtl/inv_trans_divider.sv | 125 ++++++++++++
 tb/tb_inv_trans_divider.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_trans_divider.sv
// Iterative restoring divider producing 1/t (Q2.6) from a Q0.8 transmission, one quotient bit per clock.
// Optional round-to-nearest is enabled by defining INV_TRANS_ROUND_EN; otherwise the result is truncated.
module inv_trans_divider #(
    parameter int unsigned T_MIN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] trans_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] inv_trans,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       clamp_flag,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  teff_q, teff_d;
    logic        clamp_q, clamp_d;
    logic [15:0] rem_q, rem_d;
    logic [14:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  inv_q, inv_d;

    logic [7:0]  tMin;
    logic        needClamp;
    logic [15:0] remShift;
    logic        take;
    logic [15:0] remNext;
    logic [14:0] quoNext;
    logic [15:0] quoFinal;
    logic [7:0]  resultSat;

    assign tMin      = T_MIN[7:0];
    assign needClamp = (trans_in < tMin);

    // The dividend is 2^14, so the only bit shifted in is a one on the first step.
    // A bit falling out of the remainder top means the shifted value already exceeds t_eff.
    assign remShift = {rem_q[14:0], (cnt_q == 4'd14)};
    assign take     = rem_q[15] | (remShift >= {8'b0, teff_q});
    assign remNext  = take ? (remShift - {8'b0, teff_q}) : remShift;
    assign quoNext  = quo_q | ({14'b0, take} << cnt_q);

`ifdef INV_TRANS_ROUND_EN
    logic roundUp;
    assign roundUp  = ({remNext, 1'b0} >= {9'b0, teff_q});
    assign quoFinal = {1'b0, quoNext} + {15'b0, roundUp};
`else
    assign quoFinal = {1'b0, quoNext};
`endif

    assign resultSat = ((teff_q == 8'd0) || (quoFinal > 16'd255)) ? 8'hFF : quoFinal[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            teff_q  <= 8'd0;
            clamp_q <= 1'b0;
            rem_q   <= 16'd0;
            quo_q   <= 15'd0;
            cnt_q   <= 4'd0;
            inv_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            teff_q  <= teff_d;
            clamp_q <= clamp_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        teff_d  = teff_q;
        clamp_d = clamp_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    teff_d  = needClamp ? tMin : trans_in;
                    clamp_d = needClamp;
                    rem_d   = 16'd0;
                    quo_d   = 15'd0;
                    cnt_d   = 4'd14;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = remNext;
                quo_d = quoNext;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd0;
                    inv_d   = resultSat;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign inv_trans  = inv_q;
    assign clamp_flag = clamp_q;

endmodule

// File: tb/tb_inv_trans_divider.sv
// Self-checking bench for inv_trans_divider: a default T_MIN=64 unit and a T_MIN=0 unit share stimulus.
// Expected results follow the rounding mode selected by INV_TRANS_ROUND_EN.
module tb_inv_trans_divider;

    logic       clk;
    logic       rst;
    logic [7:0] trans_in;
    logic       in_valid;
    logic       out_ready;

    logic       inReadyA, outValidA, clampA, busyA;
    logic [7:0] invA;
    logic       inReadyZ, outValidZ, clampZ, busyZ;
    logic [7:0] invZ;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    int acceptQ[$];

    typedef struct {
        logic [7:0] trans;
        logic [7:0] expA;
        logic       expClampA;
        logic [7:0] expZ;
    } vec_t;

    inv_trans_divider dutA (
        .clk(clk), .rst(rst), .trans_in(trans_in), .in_valid(in_valid),
        .in_ready(inReadyA), .inv_trans(invA), .out_valid(outValidA),
        .out_ready(out_ready), .clamp_flag(clampA), .busy(busyA)
    );

    inv_trans_divider #(.T_MIN(0)) dutZ (
        .clk(clk), .rst(rst), .trans_in(trans_in), .in_valid(in_valid),
        .in_ready(inReadyZ), .inv_trans(invZ), .out_valid(outValidZ),
        .out_ready(out_ready), .clamp_flag(clampZ), .busy(busyZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count and a log of every accepting edge on the default unit.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && inReadyA) acceptQ.push_back(cyc);
    end

    // Reference: clamp, integer division, optional round-to-nearest, saturate to 255.
    function automatic logic [8:0] refModel(input int t, input int tmin);
        int teff, q, r;
        teff = (t < tmin) ? tmin : t;
        if (teff == 0) return {1'b0, 8'd255};
        q = 16384 / teff;
        r = 16384 % teff;
`ifdef INV_TRANS_ROUND_EN
        if (2 * r >= teff) q = q + 1;
`endif
        if (q > 255) q = 255;
        return {(t < tmin) ? 1'b1 : 1'b0, q[7:0]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Runs one transaction on both units; hold > 0 stalls the consumer for that many cycles.
    task automatic applyStimulus(input logic [7:0] t, input int hold, input logic [7:0] expA,
                                 input logic expClampA, input logic [7:0] expZ);
        int k;
        @(negedge clk);
        trans_in  = t;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        k = 0;
        while (!inReadyA && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("accept_ready", int'(inReadyA), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        trans_in = 8'($urandom);
        @(negedge clk);
        checkOutput("calc_in_ready", int'(inReadyA), 0);
        checkOutput("calc_busy", int'(busyA), 1);
        k = 0;
        while (!outValidA && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("latency", k, 15);
        checkOutput("inv_a", int'(invA), int'(expA));
        checkOutput("clamp_a", int'(clampA), int'(expClampA));
        checkOutput("valid_z", int'(outValidZ), 1);
        checkOutput("inv_z", int'(invZ), int'(expZ));
        checkOutput("clamp_z", int'(clampZ), 0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i == 1) begin
                    in_valid = 1'b1;
                    trans_in = 8'd50;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                checkOutput("bp_valid", int'(outValidA), 1);
                checkOutput("bp_inv", int'(invA), int'(expA));
                checkOutput("bp_in_ready", int'(inReadyA), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("post_valid", int'(outValidA), 0);
        checkOutput("post_ready", int'(inReadyA), 1);
        checkOutput("post_busy", int'(busyA), 0);
    endtask

    vec_t vecs[8];
    logic [8:0] mA, mZ;
    int k;

    initial begin
        rst       = 1'b1;
        trans_in  = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

`ifdef INV_TRANS_ROUND_EN
        vecs[2] = '{8'd200, 8'd82, 1'b0, 8'd82};
        vecs[3] = '{8'd100, 8'd164, 1'b0, 8'd164};
`else
        vecs[2] = '{8'd200, 8'd81, 1'b0, 8'd81};
        vecs[3] = '{8'd100, 8'd163, 1'b0, 8'd163};
`endif
        vecs[0] = '{8'd128, 8'd128, 1'b0, 8'd128};
        vecs[1] = '{8'd255, 8'd64, 1'b0, 8'd64};
        vecs[4] = '{8'd64, 8'd255, 1'b0, 8'd255};
        vecs[5] = '{8'd10, 8'd255, 1'b1, 8'd255};
        vecs[6] = '{8'd0, 8'd255, 1'b1, 8'd255};
        vecs[7] = '{8'd1, 8'd255, 1'b1, 8'd255};

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", int'(inReadyA), 1);
        checkOutput("rst_out_valid", int'(outValidA), 0);
        checkOutput("rst_inv", int'(invA), 0);
        checkOutput("rst_clamp", int'(clampA), 0);
        checkOutput("rst_busy", int'(busyA), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rel_in_ready", int'(inReadyA), 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].trans, 0, vecs[i].expA, vecs[i].expClampA, vecs[i].expZ);
        end

        mA = refModel(150, 64);
        mZ = refModel(150, 0);
        applyStimulus(8'd150, 5, mA[7:0], mA[8], mZ[7:0]);
        mA = refModel(90, 64);
        mZ = refModel(90, 0);
        applyStimulus(8'd90, 0, mA[7:0], mA[8], mZ[7:0]);

        for (int i = 0; i < 20; i++) begin
            int t;
            t  = int'($urandom_range(0, 255));
            mA = refModel(t, 64);
            mZ = refModel(t, 0);
            applyStimulus(8'(t), 0, mA[7:0], mA[8], mZ[7:0]);
        end

        // Back-to-back accepts with in_valid and out_ready held high.
        @(negedge clk);
        acceptQ.delete();
        trans_in  = 8'd128;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (acceptQ.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("tput_accepts", acceptQ.size(), 2);
        if (acceptQ.size() >= 2) checkOutput("tput_interval", acceptQ[1] - acceptQ[0], 17);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("tput_idle", int'(inReadyA), 1);
        checkOutput("tput_inv", int'(invA), 128);

        // Asynchronous reset in the middle of a calculation.
        mA = refModel(200, 64);
        applyStimulus(8'd200, 0, mA[7:0], mA[8], mA[7:0]);
        @(negedge clk);
        trans_in = 8'd128;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("mid_busy_before", int'(busyA), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", int'(outValidA), 0);
        checkOutput("mid_rst_inv", int'(invA), 0);
        checkOutput("mid_rst_busy", int'(busyA), 0);
        checkOutput("mid_rst_inv_z", int'(invZ), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd128, 0, 8'd128, 1'b0, 8'd128);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
